// File: rtl/rstgen_pkg.sv
// Shared types and constants for the reset sequencer.
package rstgen_pkg;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_WAIT_LOCK,
    ST_QUALIFY,
    ST_REL_PERIPH,
    ST_RUN,
    ST_HOLD
  } rstgen_state_t;

  // Shortened windows used when the top is built for fast simulation.
  localparam int unsigned TB_LOCK_CYCLES = 4;
  localparam int unsigned TB_STAGE_GAP   = 2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer with optional asynchronous clear (async assert, sync release).
module sync_ff #(
  parameter int unsigned STAGES = 2,
  parameter bit          CLR_EN = 1'b1
) (
  input  logic i_clk,
  input  logic i_clr_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;
  logic              w_clr_n;

  // With the clear disabled the async reset pin is tied inactive and folds away.
  assign w_clr_n = i_clr_n | ~CLR_EN;

  always_ff @(posedge i_clk or negedge w_clr_n) begin
    if (!w_clr_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/rstgen.sv
// Reset sequencer: qualifies clkgen lock, then releases peripheral and core resets in order.
module rstgen
  import rstgen_pkg::*;
#(
  parameter int unsigned TB_MODE     = 0,
  parameter int unsigned LOCK_CYCLES = 1024,
  parameter int unsigned STAGE_GAP   = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic locked,
  input  logic soft_rst,
  output logic periph_rst_n,
  output logic core_rst_n,
  output logic ready,
  output logic lock_lost
);

  localparam int unsigned LOCK_EFF = (TB_MODE != 0) ? TB_LOCK_CYCLES : LOCK_CYCLES;
  localparam int unsigned GAP_EFF  = (TB_MODE != 0) ? TB_STAGE_GAP : STAGE_GAP;
  localparam int unsigned CW       = $clog2(max_u(LOCK_EFF, GAP_EFF) + 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_EFF - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_EFF - 1);

  logic          w_srst_n;
  logic          w_locked_s;
  rstgen_state_t r_state;
  rstgen_state_t w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_lost_set;

  sync_ff #(.STAGES(SYNC_STAGES), .CLR_EN(1'b1)) u_rst_sync (
    .i_clk   (clk),
    .i_clr_n (rst_n),
    .i_d     (1'b1),
    .o_q     (w_srst_n)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .CLR_EN(1'b1)) u_lock_sync (
    .i_clk   (clk),
    .i_clr_n (rst_n),
    .i_d     (locked),
    .o_q     (w_locked_s)
  );

  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lost_set  = 1'b0;
    case (r_state)
      ST_RESET: begin
        w_state_nxt = ST_WAIT_LOCK;
        w_cnt_nxt   = '0;
      end
      ST_WAIT_LOCK: begin
        if (w_locked_s) begin
          w_state_nxt = ST_QUALIFY;
          w_cnt_nxt   = '0;
        end
      end
      ST_QUALIFY: begin
        if (!w_locked_s) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (r_cnt == LOCK_LAST) begin
          w_state_nxt = ST_REL_PERIPH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_REL_PERIPH, ST_HOLD: begin
        if (!w_locked_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_lost_set  = 1'b1;
        end else if (r_cnt == GAP_LAST) begin
          w_state_nxt = (r_state == ST_HOLD) ? ST_REL_PERIPH : ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_RUN: begin
        // Lock loss outranks a simultaneous soft reset request.
        if (!w_locked_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_lost_set  = 1'b1;
        end else if (soft_rst) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_RESET;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they flip on the same edge as the state.
  always_ff @(posedge clk or negedge w_srst_n) begin
    if (!w_srst_n) begin
      r_state      <= ST_RESET;
      r_cnt        <= '0;
      periph_rst_n <= 1'b0;
      core_rst_n   <= 1'b0;
      ready        <= 1'b0;
      lock_lost    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      periph_rst_n <= (w_state_nxt == ST_REL_PERIPH) || (w_state_nxt == ST_RUN);
      core_rst_n   <= (w_state_nxt == ST_RUN);
      ready        <= (w_state_nxt == ST_RUN);
      if (w_lost_set) begin
        lock_lost <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rstgen.sv
// Directed bench for rstgen with LOCK_CYCLES=8, STAGE_GAP=4, SYNC_STAGES=2.
module tb_rstgen;

  logic clk      = 1'b0;
  logic clk_en   = 1'b1;
  logic rst_n    = 1'b0;
  logic locked   = 1'b0;
  logic soft_rst = 1'b0;
  logic periph_rst_n, core_rst_n, ready, lock_lost;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 if (clk_en) clk = ~clk;

  rstgen #(
    .TB_MODE     (0),
    .LOCK_CYCLES (8),
    .STAGE_GAP   (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .locked       (locked),
    .soft_rst     (soft_rst),
    .periph_rst_n (periph_rst_n),
    .core_rst_n   (core_rst_n),
    .ready        (ready),
    .lock_lost    (lock_lost)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    rst_n    = 1'b0;
    soft_rst = 1'b0;
    repeat (3) tick();
  endtask

  // Vectors below are {periph_rst_n, core_rst_n, ready, lock_lost}.
  task automatic test_reset();
    logic [3:0] got;
    locked = 1'b1;
    hold_reset();
    got = {periph_rst_n, core_rst_n, ready, lock_lost};
    n_checks++;
    if (got !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_values: got %b, want 0000", got);
    end
  endtask

  // rst_n released at edge 0: srst_n at 2, QUALIFY at 4, periph at 12, core at 16.
  task automatic test_release_order();
    logic [3:0] got, exp;
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      got = {periph_rst_n, core_rst_n, ready, lock_lost};
      exp = {k >= 12, k >= 16, k >= 16, 1'b0};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL release_order k=%0d: got %b, want %b", k, got, exp);
      end
    end
  endtask

  // locked low for one cycle so QUALIFY sees locked_s=0 at count 5; window restarts at edge 11.
  task automatic test_lock_glitch();
    logic [3:0] got, exp;
    hold_reset();
    locked = 1'b1;
    rst_n  = 1'b1;
    for (int k = 1; k <= 23; k++) begin
      tick();
      got = {periph_rst_n, core_rst_n, ready, lock_lost};
      exp = {k >= 19, k >= 23, k >= 23, 1'b0};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL lock_glitch k=%0d: got %b, want %b", k, got, exp);
      end
      if (k == 7) locked = 1'b0;
      if (k == 8) locked = 1'b1;
    end
  endtask

  // From RUN: locked_s falls at edge 2, resets drop at 3; relock after 3 gives QUALIFY at 6.
  task automatic test_lock_loss();
    logic [3:0] got, exp;
    locked = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      got = {periph_rst_n, core_rst_n, ready, lock_lost};
      exp = {(k < 3) || (k >= 14), (k < 3) || (k >= 18), (k < 3) || (k >= 18), k >= 3};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL lock_loss k=%0d: got %b, want %b", k, got, exp);
      end
      if (k == 3) locked = 1'b1;
    end
  endtask

  // soft_rst seen at edge 1: HOLD 1..4, periph at 5, core at 9; a pulse in REL_PERIPH is ignored.
  task automatic test_soft_rst();
    logic [3:0] got, exp;
    soft_rst = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      got = {periph_rst_n, core_rst_n, ready, lock_lost};
      exp = {k >= 5, k >= 9, k >= 9, 1'b1};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL soft_rst k=%0d: got %b, want %b", k, got, exp);
      end
      if (k == 1) soft_rst = 1'b0;
      if (k == 6) soft_rst = 1'b1;
      if (k == 7) soft_rst = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] got, exp;
    hold_reset();
    locked = 1'b1;
    rst_n  = 1'b1;
    repeat (13) tick();
    got = {periph_rst_n, core_rst_n, ready, lock_lost};
    n_checks++;
    if (got !== 4'b1000) begin
      n_errors++;
      $display("FAIL async_pre_rel_periph: got %b, want 1000", got);
    end
    clk_en = 1'b0;
    #20;
    rst_n = 1'b0;
    #3;
    got = {periph_rst_n, core_rst_n, ready, lock_lost};
    n_checks++;
    if (got !== 4'b0000) begin
      n_errors++;
      $display("FAIL async_assert_noclk: got %b, want 0000", got);
    end
    clk_en = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      got = {periph_rst_n, core_rst_n, ready, lock_lost};
      exp = {k >= 12, k >= 16, k >= 16, 1'b0};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL async_restart k=%0d: got %b, want %b", k, got, exp);
      end
    end
  endtask

  // FSM sees locked_s=0 and soft_rst=1 together at edge 3: WAIT_LOCK with lock_lost, no HOLD release.
  task automatic test_soft_vs_lockloss();
    logic [3:0] got, exp;
    locked = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      got = {periph_rst_n, core_rst_n, ready, lock_lost};
      exp = (k <= 2) ? 4'b1110 : 4'b0001;
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL soft_vs_lockloss k=%0d: got %b, want %b", k, got, exp);
      end
      if (k == 2) soft_rst = 1'b1;
      if (k == 3) soft_rst = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_release_order();
    test_lock_glitch();
    test_lock_loss();
    test_soft_rst();
    test_async_reset();
    test_soft_vs_lockloss();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
